// File: rtl/truth_table_capture.sv
// Sweeps a 4-bit code over a combinational unit under test and captures its 1-bit
// response per code into a 16-entry truth table with a running population count.
module truth_table_capture #(
  parameter int unsigned HOLD_CYCLES = 20
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        y_in,
  output logic [3:0]  i_out,
  output logic        busy,
  output logic        done,
  output logic        valid,
  output logic [15:0] table_out,
  output logic [4:0]  ones_count
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);

  state_t      state_q, state_d;
  logic [3:0]  code_q, code_d;
  logic [7:0]  hold_q, hold_d;
  logic [15:0] table_q, table_d;
  logic [4:0]  ones_q, ones_d;
  logic        valid_q, valid_d;
  logic [3:0]  i_out_q, i_out_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  // Next-state, capture and output decode; outputs are precomputed from next state.
  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    hold_d  = hold_q;
    table_d = table_q;
    ones_d  = ones_q;
    valid_d = valid_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          code_d  = 4'h0;
          hold_d  = 8'h00;
          table_d = 16'h0000;
          ones_d  = 5'd0;
          valid_d = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (hold_q == HOLD_LAST) begin
          table_d[code_q] = y_in;
          ones_d          = ones_q + {4'b0000, y_in};
          hold_d          = 8'h00;
          // Code 15 ends the sweep instead of wrapping back to 0.
          if (code_q == 4'hF) begin
            state_d = DONE;
            valid_d = 1'b1;
          end else begin
            code_d = code_q + 4'h1;
          end
        end else begin
          hold_d = hold_q + 8'h01;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    i_out_d = (state_d == RUN) ? code_d : 4'h0;
    busy_d  = (state_d == RUN);
    done_d  = (state_d == DONE);
  end

  // State and output registers; reset clears everything without waiting for a clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      code_q  <= 4'h0;
      hold_q  <= 8'h00;
      table_q <= 16'h0000;
      ones_q  <= 5'd0;
      valid_q <= 1'b0;
      i_out_q <= 4'h0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      hold_q  <= hold_d;
      table_q <= table_d;
      ones_q  <= ones_d;
      valid_q <= valid_d;
      i_out_q <= i_out_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign i_out      = i_out_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign valid      = valid_q;
  assign table_out  = table_q;
  assign ones_count = ones_q;

endmodule

// File: tb/tb_truth_table_capture.sv
// Directed bench for truth_table_capture: three instances (HOLD_CYCLES 2, 3, 1) with
// expected tables queued at start and checked when each done pulse appears.
module tb_truth_table_capture;

  localparam int HA = 2;
  localparam int HB = 3;
  localparam int HC = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic        rst_n_a, rst_n_bc;
  logic        start_a, start_b, start_c;
  logic        mode_a;
  logic        y_in_a, y_in_b, y_in_c;
  logic [3:0]  i_out_a, i_out_b, i_out_c;
  logic        busy_a, busy_b, busy_c;
  logic        done_a, done_b, done_c;
  logic        valid_a, valid_b, valid_c;
  logic [15:0] table_a, table_b, table_c;
  logic [4:0]  ones_a, ones_b, ones_c;

  logic [15:0] q_a[$];
  logic [15:0] q_b[$];
  logic [15:0] q_c[$];
  int busy_cnt_a = 0, busy_cnt_b = 0, busy_cnt_c = 0;
  int done_cnt_a = 0, done_cnt_b = 0, done_cnt_c = 0;
  int run_a = 0;
  int ph_b = 0;
  logic tog_b = 1'b0;

  truth_table_capture #(.HOLD_CYCLES(HA)) u_a (
    .clk(clk), .rst_n(rst_n_a), .start(start_a), .y_in(y_in_a), .i_out(i_out_a),
    .busy(busy_a), .done(done_a), .valid(valid_a), .table_out(table_a), .ones_count(ones_a)
  );
  truth_table_capture #(.HOLD_CYCLES(HB)) u_b (
    .clk(clk), .rst_n(rst_n_bc), .start(start_b), .y_in(y_in_b), .i_out(i_out_b),
    .busy(busy_b), .done(done_b), .valid(valid_b), .table_out(table_b), .ones_count(ones_b)
  );
  truth_table_capture #(.HOLD_CYCLES(HC)) u_c (
    .clk(clk), .rst_n(rst_n_bc), .start(start_c), .y_in(y_in_c), .i_out(i_out_c),
    .busy(busy_c), .done(done_c), .valid(valid_c), .table_out(table_c), .ones_count(ones_c)
  );

  // Units under test: AND/XOR of the code, a last-cycle-only probe, and constant 1.
  assign y_in_a = mode_a ? ^i_out_a : &i_out_a;
  assign y_in_b = (ph_b == HB - 1) ? i_out_b[0] : ((ph_b == 1) ? ~i_out_b[0] : tog_b);
  assign y_in_c = 1'b1;

  always @(posedge clk) begin
    tog_b <= ~tog_b;
    if (busy_b) ph_b <= (ph_b == HB - 1) ? 0 : ph_b + 1;
    else        ph_b <= 0;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard and per-cycle monitors, sampled on the falling edge.
  always @(negedge clk) begin
    logic [15:0] e;
    if (busy_a) begin
      check("a_i_out_run", 32'(i_out_a), 32'(run_a / HA));
      check("a_valid_run", 32'(valid_a), 32'd0);
      run_a++;
      busy_cnt_a++;
    end else begin
      check("a_i_out_idle", 32'(i_out_a), 32'd0);
      run_a = 0;
    end
    check("a_popcount", 32'(ones_a), 32'($countones(table_a)));
    if (done_a) begin
      done_cnt_a++;
      if (q_a.size() == 0) check("a_unexpected_done", 32'(done_a), 32'd0);
      else begin
        e = q_a.pop_front();
        check("a_table", 32'(table_a), 32'(e));
        check("a_ones", 32'(ones_a), 32'($countones(e)));
        check("a_valid_done", 32'(valid_a), 32'd1);
        check("a_busy_done", 32'(busy_a), 32'd0);
      end
    end
    if (busy_b) busy_cnt_b++;
    if (done_b) begin
      done_cnt_b++;
      if (q_b.size() == 0) check("b_unexpected_done", 32'(done_b), 32'd0);
      else begin
        e = q_b.pop_front();
        check("b_table", 32'(table_b), 32'(e));
        check("b_ones", 32'(ones_b), 32'($countones(e)));
      end
    end
    if (busy_c) busy_cnt_c++;
    if (done_c) begin
      done_cnt_c++;
      if (q_c.size() == 0) check("c_unexpected_done", 32'(done_c), 32'd0);
      else begin
        e = q_c.pop_front();
        check("c_table", 32'(table_c), 32'(e));
        check("c_ones", 32'(ones_c), 32'($countones(e)));
        check("c_i_out_done", 32'(i_out_c), 32'd0);
      end
    end
  end

  task automatic sweep_a(input logic [15:0] exp_tbl, input bit extra);
    int cyc;
    int b0;
    int d0;
    q_a.push_back(exp_tbl);
    b0 = busy_cnt_a;
    d0 = done_cnt_a;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    cyc = 1;
    while (!done_a && cyc < 200) begin
      start_a = extra && (cyc == 5);
      tick();
      cyc++;
    end
    start_a = 1'b0;
    check("a_done_cycle", 32'(cyc), 32'(16 * HA + 1));
    check("a_busy_len", 32'(busy_cnt_a - b0), 32'(16 * HA));
    tick();
    check("a_valid_hold", 32'(valid_a), 32'd1);
    check("a_done_low", 32'(done_a), 32'd0);
    check("a_table_hold", 32'(table_a), 32'(exp_tbl));
    repeat (3) tick();
    check("a_done_pulses", 32'(done_cnt_a - d0), 32'd1);
  endtask

  initial begin
    int cyc;
    int n;
    rst_n_a  = 1'b0;
    rst_n_bc = 1'b0;
    start_a  = 1'b0;
    start_b  = 1'b0;
    start_c  = 1'b0;
    mode_a   = 1'b0;
    #12;
    check("rst_i_out", 32'(i_out_a), 32'd0);
    check("rst_busy", 32'(busy_a), 32'd0);
    check("rst_done", 32'(done_a), 32'd0);
    check("rst_valid", 32'(valid_a), 32'd0);
    check("rst_table", 32'(table_a), 32'd0);
    check("rst_ones", 32'(ones_a), 32'd0);
    check("rst_c_busy", 32'(busy_c), 32'd0);
    tick();
    rst_n_a  = 1'b1;
    rst_n_bc = 1'b1;

    // AND table, then XOR table with a stray start mid-sweep.
    sweep_a(16'h8000, 1'b0);
    mode_a = 1'b1;
    sweep_a(16'h6996, 1'b1);

    // Abort at code 7 with an asynchronous reset, then sweep again.
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    n = 0;
    while (i_out_a != 4'd7 && n < 100) begin
      tick();
      n++;
    end
    check("a_reached_code7", 32'(i_out_a), 32'd7);
    #2;
    rst_n_a = 1'b0;
    #1;
    check("arst_i_out", 32'(i_out_a), 32'd0);
    check("arst_busy", 32'(busy_a), 32'd0);
    check("arst_valid", 32'(valid_a), 32'd0);
    check("arst_table", 32'(table_a), 32'd0);
    check("arst_ones", 32'(ones_a), 32'd0);
    repeat (2) tick();
    rst_n_a = 1'b1;
    repeat (40) tick();
    check("arst_no_done", 32'(done_cnt_a), 32'd2);
    sweep_a(16'h6996, 1'b0);
    check("a_queue_empty", 32'(q_a.size()), 32'd0);

    // HOLD_CYCLES=3: only the last hold cycle of each code is captured.
    q_b.push_back(16'hAAAA);
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    cyc = 1;
    while (!done_b && cyc < 200) begin
      tick();
      cyc++;
    end
    check("b_done_cycle", 32'(cyc), 32'(16 * HB + 1));
    check("b_busy_len", 32'(busy_cnt_b), 32'(16 * HB));
    repeat (2) tick();
    check("b_done_pulses", 32'(done_cnt_b), 32'd1);

    // HOLD_CYCLES=1 with start held: back-to-back sweeps separated by one IDLE cycle.
    q_c.push_back(16'hFFFF);
    q_c.push_back(16'hFFFF);
    start_c = 1'b1;
    tick();
    cyc = 1;
    while (!done_c && cyc < 200) begin
      tick();
      cyc++;
    end
    check("c_done_cycle1", 32'(cyc), 32'(16 * HC + 1));
    tick();
    cyc++;
    check("c_idle_gap_busy", 32'(busy_c), 32'd0);
    check("c_idle_gap_valid", 32'(valid_c), 32'd1);
    tick();
    cyc++;
    check("c_rerun_busy", 32'(busy_c), 32'd1);
    check("c_rerun_valid", 32'(valid_c), 32'd0);
    while (!done_c && cyc < 200) begin
      tick();
      cyc++;
    end
    check("c_done_cycle2", 32'(cyc), 32'(2 * (16 * HC + 1) + 1));
    start_c = 1'b0;
    repeat (4) tick();
    check("c_done_pulses", 32'(done_cnt_c), 32'd2);
    check("c_busy_len", 32'(busy_cnt_c), 32'(2 * 16 * HC));
    check("c_queue_empty", 32'(q_c.size()), 32'd0);
    check("c_valid_after", 32'(valid_c), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
